issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter.sv | 132 +++++++++++++
 tb/tb_issue_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_arbiter.sv
// Result-bus arbiter: fixed-latency multiplier with reserved CDB slots plus
// round-robin single-cycle channels, all funnelled onto one registered CDB.
module issue_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5,
  parameter int MULT_LAT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CH-1:0]          ready_i,
  input  logic [NUM_CH*TAG_W-1:0]    ch_tag_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0]          ch_branch_i,
  input  logic [NUM_CH-1:0]          ch_branch_taken_i,
  output logic [NUM_CH-1:0]          issue_o,
  input  logic                       ready_mult_i,
  input  logic [TAG_W-1:0]           mult_tag_i,
  input  logic [DATA_W-1:0]          mult_result_i,
  output logic                       issue_mult_o,
  input  logic                       rb_flush_valid_i,
  output logic [TAG_W-1:0]           cdb_tag_o,
  output logic [DATA_W-1:0]          cdb_data_o,
  output logic                       cdb_valid_o,
  output logic                       cdb_branch_o,
  output logic                       cdb_branch_taken_o
);

  localparam int PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0] ptr_q;
  logic             prev_mult_q;
  logic             res_q      [MULT_LAT];
  logic [TAG_W-1:0] tag_pipe_q [MULT_LAT];

  logic              reserved_c;
  logic              issue_mult_c;
  logic              grant_any_c;
  logic [PTR_W-1:0]  grant_idx_c;
  logic [PTR_W-1:0]  scan_idx_c;
  logic [NUM_CH-1:0] issue_c;
  logic [PTR_W-1:0]  ptr_d;
  logic [TAG_W-1:0]  sel_tag_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              sel_br_c;
  logic              sel_bt_c;
  int                scan_k;

  // A set bit at the pipe exit means the CDB belongs to the multiplier this cycle.
  assign reserved_c = res_q[MULT_LAT-1];

  always_comb begin
    issue_mult_c = rst_ni & ready_mult_i & ~reserved_c & ~rb_flush_valid_i & ~prev_mult_q;
    grant_any_c  = 1'b0;
    grant_idx_c  = '0;
    scan_idx_c   = '0;
    scan_k       = 0;
    issue_c      = '0;
    if (rst_ni && !reserved_c && !issue_mult_c && !rb_flush_valid_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scan_k = int'(ptr_q) + i;
        if (scan_k >= NUM_CH) scan_k = scan_k - NUM_CH;
        scan_idx_c = PTR_W'(scan_k);
        if (!grant_any_c && ready_i[scan_idx_c]) begin
          grant_any_c = 1'b1;
          grant_idx_c = scan_idx_c;
        end
      end
    end
    if (grant_any_c) issue_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    ptr_d      = (grant_idx_c == PTR_W'(NUM_CH-1)) ? '0 : grant_idx_c + 1'b1;
    sel_tag_c  = ch_tag_i[grant_idx_c*TAG_W +: TAG_W];
    sel_data_c = ch_data_i[grant_idx_c*DATA_W +: DATA_W];
    sel_br_c   = ch_branch_i[grant_idx_c];
    sel_bt_c   = ch_branch_taken_i[grant_idx_c];
  end

  assign issue_o      = issue_c;
  assign issue_mult_o = issue_mult_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q              <= '0;
      prev_mult_q        <= 1'b0;
      cdb_tag_o          <= '0;
      cdb_data_o         <= '0;
      cdb_valid_o        <= 1'b0;
      cdb_branch_o       <= 1'b0;
      cdb_branch_taken_o <= 1'b0;
      for (int i = 0; i < MULT_LAT; i++) begin
        res_q[i]      <= 1'b0;
        tag_pipe_q[i] <= '0;
      end
    end else begin
      prev_mult_q <= issue_mult_c;
      if (rb_flush_valid_i) begin
        cdb_valid_o <= 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
          res_q[i]      <= 1'b0;
          tag_pipe_q[i] <= '0;
        end
      end else begin
        res_q[0]      <= issue_mult_c;
        tag_pipe_q[0] <= mult_tag_i;
        for (int i = 1; i < MULT_LAT; i++) begin
          res_q[i]      <= res_q[i-1];
          tag_pipe_q[i] <= tag_pipe_q[i-1];
        end
        if (reserved_c) begin
          cdb_valid_o        <= 1'b1;
          cdb_tag_o          <= tag_pipe_q[MULT_LAT-1];
          cdb_data_o         <= mult_result_i;
          cdb_branch_o       <= 1'b0;
          cdb_branch_taken_o <= 1'b0;
        end else if (grant_any_c) begin
          cdb_valid_o        <= 1'b1;
          cdb_tag_o          <= sel_tag_c;
          cdb_data_o         <= sel_data_c;
          cdb_branch_o       <= sel_br_c;
          cdb_branch_taken_o <= sel_bt_c;
          ptr_q              <= ptr_d;
        end else begin
          cdb_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter: directed scenarios then random traffic, checked each
// cycle against a model that tracks pending multiplies as (due cycle, tag) entries.
module tb_issue_arbiter;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NC-1:0]  ready;
  logic [NC*TW-1:0] ch_tag;
  logic [NC*DW-1:0] ch_data;
  logic [NC-1:0]  ch_br, ch_bt;
  logic [NC-1:0]  issue;
  logic           ready_mult;
  logic [TW-1:0]  mult_tag;
  logic [DW-1:0]  mult_result;
  logic           issue_mult;
  logic           flush;
  logic [TW-1:0]  cdb_tag;
  logic [DW-1:0]  cdb_data;
  logic           cdb_valid, cdb_br, cdb_bt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  issue_arbiter #(.NUM_CH(NC), .DATA_W(DW), .TAG_W(TW), .MULT_LAT(ML)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ready_i(ready), .ch_tag_i(ch_tag), .ch_data_i(ch_data),
    .ch_branch_i(ch_br), .ch_branch_taken_i(ch_bt), .issue_o(issue),
    .ready_mult_i(ready_mult), .mult_tag_i(mult_tag), .mult_result_i(mult_result),
    .issue_mult_o(issue_mult), .rb_flush_valid_i(flush),
    .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data), .cdb_valid_o(cdb_valid),
    .cdb_branch_o(cdb_br), .cdb_branch_taken_o(cdb_bt));

  typedef struct {
    int            due;
    logic [TW-1:0] tag;
  } pend_t;

  pend_t         pend[$];
  int            cyc;
  int            m_p;
  bit            m_last_mult;
  logic          m_valid, m_br, m_bt;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cyc = 0; m_p = 0; m_last_mult = 0;
    m_valid = 0; m_br = 0; m_bt = 0; m_tag = '0; m_data = '0;
  endtask

  // Entered just after a rising edge with this cycle's inputs already driven.
  task automatic step();
    bit            res;
    int            rj, gk, k;
    logic [TW-1:0] rtag;
    bit            exp_im;
    logic [NC-1:0] exp_issue;
    @(negedge clk);
    res = 0; rj = -1; rtag = '0; gk = -1;
    foreach (pend[j]) if (pend[j].due == cyc) begin res = 1; rj = j; rtag = pend[j].tag; end
    exp_im = ready_mult && !res && !flush && !m_last_mult;
    if (!res && !exp_im && !flush)
      for (int i = 0; i < NC; i++) begin
        k = (m_p + i) % NC;
        if (ready[k]) begin gk = k; break; end
      end
    exp_issue = (gk >= 0) ? NC'(1 << gk) : '0;
    chk("issue", issue, exp_issue);
    chk("issue_mult", issue_mult, exp_im);
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_data", cdb_data, m_data);
    chk("cdb_branch", cdb_br, m_br);
    chk("cdb_branch_taken", cdb_bt, m_bt);
    if (flush) begin
      pend.delete();
      m_valid = 0;
    end else if (res) begin
      m_valid = 1; m_tag = rtag; m_data = mult_result; m_br = 0; m_bt = 0;
      pend.delete(rj);
    end else if (gk >= 0) begin
      m_valid = 1;
      m_tag   = ch_tag[gk*TW +: TW];
      m_data  = ch_data[gk*DW +: DW];
      m_br    = ch_br[gk];
      m_bt    = ch_bt[gk];
      m_p     = (gk + 1) % NC;
    end else begin
      m_valid = 0;
    end
    if (exp_im) pend.push_back('{due: cyc + ML, tag: mult_tag});
    m_last_mult = exp_im;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    ready = '0; ready_mult = 0; flush = 0; mult_tag = '0; mult_result = '0;
    ch_br = '0; ch_bt = '0;
    for (int k = 0; k < NC; k++) begin
      ch_tag[k*TW +: TW]  = TW'(k + 1);
      ch_data[k*DW +: DW] = DW'(32'h100 * (k + 1));
    end
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    rst_n = 0; ready = '1; ready_mult = 1;
    #2;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_cdb_branch", {cdb_br, cdb_bt}, 0);
    @(negedge clk);
    chk("rst_issue", {issue_mult, issue}, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    quiet_inputs();
  endtask

  initial begin
    rst_n = 0;
    quiet_inputs();
    @(posedge clk);
    #1;
    apply_reset();

    // Round robin over four always-ready channels
    ready = 4'b1111;
    repeat (6) step();

    // Multiplier result lands in its reserved slot
    apply_reset();
    ready = 4'b0001;
    step(); step();
    ready_mult = 1; mult_tag = 5'd9;
    step();
    ready_mult = 0; mult_tag = '0;
    step(); step(); step();
    mult_result = 32'h0000_0C00;
    step();
    mult_result = '0;
    chk("mult_slot_valid", cdb_valid, 1);
    chk("mult_slot_tag", cdb_tag, 9);
    chk("mult_slot_data", cdb_data, 32'h0000_0C00);
    repeat (4) step();

    // Continuous multiplier requests alternate with channel traffic
    ready_mult = 1;
    for (int i = 0; i < 14; i++) begin
      ready = NC'($urandom);
      mult_tag = TW'($urandom);
      mult_result = $urandom;
      step();
    end

    // Flush kills an in-flight multiply
    apply_reset();
    step(); step();
    ready_mult = 1; mult_tag = 5'd7;
    step();
    ready_mult = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    step(); step();
    chk("flush_no_mult_result", cdb_valid, 0);
    repeat (4) step();

    // Reset mid-multiply discards the pending result
    apply_reset();
    step(); step(); step();
    ready_mult = 1; mult_tag = 5'd3;
    step();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_reset_idle", cdb_valid, 0);
    end

    // Branch flags travel with a channel result
    ready = 4'b0100;
    ch_tag[2*TW +: TW] = 5'd5;
    ch_br = 4'b0100; ch_bt = 4'b0100;
    step();
    ready = '0;
    chk("branch_valid", cdb_valid, 1);
    chk("branch_tag", cdb_tag, 5);
    chk("branch_flags", {cdb_br, cdb_bt}, 2'b11);
    step();

    // Random traffic with occasional flushes and resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      ready       = NC'($urandom);
      ready_mult  = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      mult_tag    = TW'($urandom);
      mult_result = $urandom;
      ch_tag      = (NC*TW)'({$urandom, $urandom});
      ch_data     = {$urandom, $urandom, $urandom, $urandom};
      ch_br       = NC'($urandom);
      ch_bt       = NC'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
